// File: rtl/eth_dma_mem.sv
// rtl/eth_dma_mem.sv - AXI4 INCR burst slave memory serving the Ethernet DMA master port
// Optional macro ETH_MEM_STALL_EN: LFSR-driven wready / new-rvalid stalls.
module eth_dma_mem #(
    parameter int                   addr_bits = 32,
    parameter int                   word_bits = 32,
    parameter int                   mem_words = 4096,
    parameter logic [addr_bits-1:0] base_addr = '0,
    parameter logic [15:0]          lfsr_seed = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     async_resetn,
    input  logic [addr_bits-1:0]     s_axi_awaddr,
    input  logic [7:0]               s_axi_awlen,
    input  logic [2:0]               s_axi_awsize,
    input  logic [1:0]               s_axi_awburst,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [word_bits-1:0]     s_axi_wdata,
    input  logic [word_bits/8-1:0]   s_axi_wstrb,
    input  logic                     s_axi_wlast,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [addr_bits-1:0]     s_axi_araddr,
    input  logic [7:0]               s_axi_arlen,
    input  logic [2:0]               s_axi_arsize,
    input  logic [1:0]               s_axi_arburst,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [word_bits-1:0]     s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready
);

    localparam int idx_bits = $clog2(mem_words);
    localparam logic [addr_bits:0] limit =
        {1'b0, base_addr} + ((addr_bits+1)'(mem_words) << 2);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                 state;
    logic                   prio_rd;
    logic [addr_bits-1:0]   addr;
    logic [7:0]             len;
    logic [7:0]             beat;
    logic                   err;
    logic                   berr;
    logic                   fetch_done;
    logic [word_bits-1:0]   mem [mem_words];

    logic [addr_bits-1:0]   off;
    logic [idx_bits-1:0]    idx;
    logic                   oor;
    logic                   bad;
    logic                   last_beat;
    logic                   in_idle;
    logic                   w_hs;
    logic                   load;
    logic                   stall;

`ifdef ETH_MEM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            lfsr <= lfsr_seed;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    logic [15:0] unused_seed;
    assign unused_seed = lfsr_seed;
    assign stall = 1'b0;
`endif

    assign off       = addr - base_addr;
    assign idx       = off[idx_bits+1:2];
    assign oor       = (addr < base_addr) || ({1'b0, addr} >= limit);
    assign bad       = err | oor;
    assign last_beat = (beat == len);

    // Address readies are gated by reset so nothing handshakes while it is held.
    assign in_idle       = async_resetn && (state == IDLE);
    assign s_axi_awready = in_idle && s_axi_awvalid && (!prio_rd || !s_axi_arvalid);
    assign s_axi_arready = in_idle && s_axi_arvalid && (prio_rd || !s_axi_awvalid);
    assign s_axi_wready  = (state == WDATA) && !stall;

    assign w_hs = s_axi_wvalid && s_axi_wready;
    // rdata is the RAM read register; it only advances when its current beat is free.
    assign load = (state == RDATA) && !fetch_done && (!s_axi_rvalid || s_axi_rready) && !stall;

    always_ff @(posedge clk) begin
        if (w_hs && !bad) begin
            for (int b = 0; b < word_bits/8; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            state        <= IDLE;
            prio_rd      <= 1'b0;
            addr         <= '0;
            len          <= '0;
            beat         <= '0;
            err          <= 1'b0;
            berr         <= 1'b0;
            fetch_done   <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
            s_axi_rlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awready) begin
                        addr  <= {s_axi_awaddr[addr_bits-1:2], 2'b00};
                        len   <= s_axi_awlen;
                        err   <= (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'd2);
                        beat  <= '0;
                        berr  <= 1'b0;
                        state <= WDATA;
                    end else if (s_axi_arready) begin
                        addr       <= {s_axi_araddr[addr_bits-1:2], 2'b00};
                        len        <= s_axi_arlen;
                        err        <= (s_axi_arburst != 2'b01) || (s_axi_arsize != 3'd2);
                        beat       <= '0;
                        fetch_done <= 1'b0;
                        state      <= RDATA;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        // wlast only flags an error; the beat count alone ends the burst.
                        if (bad || (s_axi_wlast != last_beat)) begin
                            berr <= 1'b1;
                        end
                        if (last_beat) begin
                            state        <= WRESP;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (berr || bad || !s_axi_wlast) ? 2'b10 : 2'b00;
                        end else begin
                            beat <= beat + 8'd1;
                            addr <= addr + addr_bits'(4);
                        end
                    end
                end
                WRESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        prio_rd      <= 1'b1;
                        state        <= IDLE;
                    end
                end
                RDATA: begin
                    if (load) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= bad ? '0 : mem[idx];
                        s_axi_rresp  <= bad ? 2'b10 : 2'b00;
                        s_axi_rlast  <= last_beat;
                        if (last_beat) begin
                            fetch_done <= 1'b1;
                        end else begin
                            beat <= beat + 8'd1;
                            addr <= addr + addr_bits'(4);
                        end
                    end else if (s_axi_rvalid && s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                    end
                    if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
                        s_axi_rvalid <= 1'b0;
                        prio_rd      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           off[addr_bits-1:idx_bits+2], off[1:0]};

endmodule

// File: tb/tb_eth_dma_mem.sv
// tb/tb_eth_dma_mem.sv - randomized self-checking bench for eth_dma_mem against a word-array model
module tb_eth_dma_mem;

    localparam int     MEM_WORDS = 4096;
    localparam longint BASE      = 0;

    logic        clk = 1'b0;
    logic        async_resetn;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    eth_dma_mem dut (
        .clk           (clk),
        .async_resetn  (async_resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint beat_addr(input logic [31:0] a, input int i);
        logic [31:0] w;
        w = {a[31:2], 2'b00} + 32'(4 * i);
        return longint'({32'h0, w});
    endfunction

    function automatic bit in_range(input longint a);
        return (a >= BASE) && (a < BASE + 4 * MEM_WORDS);
    endfunction

    // Applies wd/ws to the model and returns the response the burst deserves.
    function automatic logic [1:0] write_model(input logic [31:0] addr, input int len,
                                               input logic [1:0] burst, input logic [2:0] size,
                                               input int bad_beat);
        bit     err;
        bit     fail;
        longint a;
        err  = (burst != 2'b01) || (size != 3'd2);
        fail = err || (bad_beat >= 0 && bad_beat <= len);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i);
            if (err || !in_range(a)) begin
                fail = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[i][b]) ref_mem[int'((a - BASE) / 4)][8*b +: 8] = wd[i][8*b +: 8];
                end
            end
        end
        return fail ? 2'b10 : 2'b00;
    endfunction

    task automatic aw_handshake(input string tag);
        int t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_awready && t < 100);
        chk({tag, " awready"}, 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_handshake(input string tag, output int hs);
        int t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_arready && t < 100);
        chk({tag, " arready"}, 32'(s_axi_arready), 32'd1);
        hs = cyc;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic send_w_beats(input string tag, input int len, input int bad_beat);
        int t;
        for (int i = 0; i <= len; i++) begin
            s_axi_wdata  = wd[i];
            s_axi_wstrb  = ws[i];
            s_axi_wlast  = (i == len) ^ (i == bad_beat);
            s_axi_wvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!s_axi_wready && t < 100);
            chk({tag, " wready"}, 32'(s_axi_wready), 32'd1);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [1:0] exp);
        int t = 0;
        bit done = 0;
        s_axi_bready = 1'b0;
        while (!done) begin
            @(negedge clk);
            if ((s_axi_bvalid && s_axi_bready) || t > 100) begin
                done = 1;
            end else begin
                @(posedge clk); #1;
                s_axi_bready = ($urandom_range(0, 2) != 0);
                t++;
            end
        end
        chk({tag, " bvalid"}, 32'(s_axi_bvalid), 32'd1);
        chk({tag, " bresp"}, 32'(s_axi_bresp), 32'(exp));
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic read_beats(input string tag, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic [2:0] size,
                              input int mode, input int hs);
        bit          err;
        bit          first;
        bit          stalled;
        int          beat;
        int          t;
        logic [31:0] pd;
        logic [1:0]  pr;
        logic        pl;
        logic [31:0] ed;
        logic [1:0]  er;
        longint      a;
        err = (burst != 2'b01) || (size != 3'd2);
        first = 1; stalled = 0; beat = 0; t = 0; pd = '0; pr = '0; pl = 1'b0;
        s_axi_rready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (beat <= len && t < 4000) begin
            @(negedge clk);
            t++;
            if (stalled) begin
                chk({tag, " hold rvalid"}, 32'(s_axi_rvalid), 32'd1);
                chk({tag, " hold rdata"}, s_axi_rdata, pd);
                chk({tag, " hold rresp"}, 32'(s_axi_rresp), 32'(pr));
                chk({tag, " hold rlast"}, 32'(s_axi_rlast), 32'(pl));
            end
            stalled = 0;
            if (s_axi_rvalid) begin
                if (first) begin
                    chk({tag, " first rvalid latency"}, 32'(cyc - hs), 32'd2);
                    first = 0;
                end
                if (s_axi_rready) begin
                    a = beat_addr(addr, beat);
                    if (err || !in_range(a)) begin
                        ed = '0; er = 2'b10;
                    end else begin
                        ed = ref_mem[int'((a - BASE) / 4)]; er = 2'b00;
                    end
                    chk({tag, " rdata"}, s_axi_rdata, ed);
                    chk({tag, " rresp"}, 32'(s_axi_rresp), 32'(er));
                    chk({tag, " rlast"}, 32'(s_axi_rlast), 32'(beat == len));
                    beat++;
                end else begin
                    stalled = 1; pd = s_axi_rdata; pr = s_axi_rresp; pl = s_axi_rlast;
                end
            end
            @(posedge clk); #1;
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = !s_axi_rready;
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
        end
        chk({tag, " beat count"}, 32'(beat), 32'(len + 1));
        s_axi_rready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input int bad_beat);
        logic [1:0] exp;
        exp = write_model(addr, len, burst, size, bad_beat);
        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size;
        s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        aw_handshake(tag);
        send_w_beats(tag, len, bad_beat);
        wait_b(tag, exp);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input int mode);
        int hs;
        s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size;
        s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        ar_handshake(tag, hs);
        read_beats(tag, addr, len, burst, size, mode, hs);
    endtask

    initial begin
        int         hs;
        int         w;
        int         l;
        int         bb;
        int         md;
        logic [1:0] bu;
        logic [1:0] exp_b;
        logic [31:0] ad;

        async_resetn = 1'b0;
        s_axi_awaddr = 32'h100; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
        s_axi_araddr = 32'h100; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;

        #12;
        chk("reset awready", 32'(s_axi_awready), 32'd0);
        chk("reset arready", 32'(s_axi_arready), 32'd0);
        chk("reset wready", 32'(s_axi_wready), 32'd0);
        chk("reset bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("reset rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("reset bresp", 32'(s_axi_bresp), 32'd0);
        chk("reset rresp", 32'(s_axi_rresp), 32'd0);
        chk("reset rdata", s_axi_rdata, 32'd0);
        chk("reset rlast", 32'(s_axi_rlast), 32'd0);

        // Simultaneous AW+AR straight out of reset: write wins, then read wins.
        #10 async_resetn = 1'b1;
        #2;
        chk("arb first awready", 32'(s_axi_awready), 32'd1);
        chk("arb first arready", 32'(s_axi_arready), 32'd0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        wd[0] = $urandom; ws[0] = 4'hF;
        exp_b = write_model(32'h100, 0, 2'b01, 3'd2, -1);
        send_w_beats("arb w1", 0, -1);
        s_axi_awaddr = 32'h104; s_axi_awvalid = 1'b1;
        wait_b("arb w1", exp_b);
        @(negedge clk);
        chk("arb second arready", 32'(s_axi_arready), 32'd1);
        chk("arb second awready", 32'(s_axi_awready), 32'd0);
        hs = cyc;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        read_beats("arb r", 32'h100, 0, 2'b01, 3'd2, 0, hs);
        wd[0] = $urandom; ws[0] = 4'hF;
        exp_b = write_model(32'h104, 0, 2'b01, 3'd2, -1);
        aw_handshake("arb w2");
        send_w_beats("arb w2", 0, -1);
        wait_b("arb w2", exp_b);

        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write("fill", 32'h0, 255, 2'b01, 3'd2, -1);
        wd[0] = $urandom; ws[0] = 4'hF;
        do_write("fill top", 32'(4 * (MEM_WORDS - 1)), 0, 2'b01, 3'd2, -1);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'h11111111 * (i + 1); ws[i] = 4'hF; end
        do_write("basic w", 32'h40, 3, 2'b01, 3'd2, -1);
        do_read("basic r", 32'h40, 3, 2'b01, 3'd2, 0);

        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write("strb clr", 32'h0, 0, 2'b01, 3'd2, -1);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        do_write("strb w", 32'h0, 0, 2'b01, 3'd2, -1);
        do_read("strb r", 32'h0, 0, 2'b01, 3'd2, 0);

        wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write("wrap w", 32'h80, 1, 2'b10, 3'd2, -1);
        do_read("wrap r", 32'h80, 1, 2'b01, 3'd2, 0);

        do_read("oor r", 32'(4 * (MEM_WORDS - 1)), 1, 2'b01, 3'd2, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write("wlast w", 32'h200, 3, 2'b01, 3'd2, 1);
        do_read("wlast r", 32'h200, 3, 2'b01, 3'd2, 0);

        do_read("bp r", 32'h300, 15, 2'b01, 3'd2, 1);

        // Reset pulse while beat 2 of an 8-beat write is on the bus.
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        s_axi_awaddr = 32'h20; s_axi_awlen = 8'd7; s_axi_awsize = 3'd2;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        aw_handshake("rst aw");
        for (int i = 0; i < 2; i++) begin
            s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
            @(negedge clk);
            chk("rst beat wready", 32'(s_axi_wready), 32'd1);
            @(posedge clk); #1;
        end
        exp_b = write_model(32'h20, 1, 2'b01, 3'd2, -1);
        s_axi_wdata = wd[2]; s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0;
        @(negedge clk); #2;
        async_resetn = 1'b0;
        #1;
        chk("rst wready", 32'(s_axi_wready), 32'd0);
        chk("rst bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst arready", 32'(s_axi_arready), 32'd0);
        s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(posedge clk); #3;
        async_resetn = 1'b1;
        @(posedge clk); #1;
        do_read("rst r", 32'h20, 7, 2'b01, 3'd2, 0);

        for (int k = 0; k < 8; k++) begin
            w  = $urandom_range(0, 200);
            l  = $urandom_range(0, 15);
            bu = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01;
            bb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, l)) : -1;
            md = $urandom_range(0, 2);
            ad = 32'(4 * w) + 32'($urandom_range(0, 3));
            for (int i = 0; i <= l; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write("rnd w", ad, l, bu, 3'd2, bb);
            do_read("rnd r", ad, l, 2'b01, 3'd2, md);
        end
        do_read("rnd err r", 32'h10, 2, 2'b01, 3'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
